// File: rtl/spi_pkg.sv
// Package spi_pkg: state encoding and default frame geometry shared by the SPI slave engine.
// Imported by spi_slave_fsm; the optional MISO tri-state enable lives in the top (SPI_MISO_BUFE_EN).
package spi_pkg;

   localparam int   SPI_ADDR_W  = 7;
   localparam int   SPI_DATA_W  = 8;
   localparam logic SPI_RW_READ = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      GET_ADDR,
      READ_REQ,
      READ_WAIT,
      READ_SHIFT,
      WRITE_DATA,
      WRITE_STB,
      DONE
   } spi_state_t;

   function automatic int spi_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Generic MSB-first shift register with parallel load; parallel load takes priority over shifting.
// Used once for the receive path (header, then data) and once for the transmit path.
module spi_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             serial_in,
   input  logic             shift_en,
   input  logic             parallel_load,
   input  logic [WIDTH-1:0] parallel_in,
   output logic [WIDTH-1:0] parallel_out,
   output logic             serial_out
);

   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= '0;
      end else if (parallel_load) begin
         data_q <= parallel_in;
      end else if (shift_en) begin
         data_q <= {data_q[WIDTH-2:0], serial_in};
      end
   end

   assign parallel_out = data_q;
   assign serial_out   = data_q[WIDTH-1];

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI mode-0 slave protocol engine running entirely in the system clock domain on conditioned SCLK edge pulses.
// Optional macro SPI_MISO_BUFE_EN adds a miso_bufe output used to tri-state MISO at the top level.
module spi_slave_fsm
   import spi_pkg::*;
#(
   parameter int ADDR_WIDTH = SPI_ADDR_W,
   parameter int DATA_WIDTH = SPI_DATA_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cs_n,
   input  logic                  mosi,
   input  logic                  sclk_posedge,
   input  logic                  sclk_negedge,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   output logic                  mem_re,
   output logic                  miso,
   output logic                  busy
`ifdef SPI_MISO_BUFE_EN
   ,
   output logic                  miso_bufe
`endif
);

   localparam int RX_W  = spi_max(ADDR_WIDTH + 1, DATA_WIDTH);
   localparam int CNT_W = $clog2(RX_W + 1);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

   spi_state_t       state, next_state;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             read_flag, read_flag_next;
   logic             rx_shift, tx_load, tx_shift, miso_upd;
   logic             addr_load, wdata_load, mem_we_c, mem_re_c;
   logic [RX_W-1:0]  rx_q, rx_next;
   logic             rx_serial;
   logic [DATA_WIDTH-1:0] tx_q;
   logic             tx_msb;
   logic             unused_bits;

   spi_shift_reg #(.WIDTH(RX_W)) u_rx (
      .clk           (clk),
      .reset         (reset),
      .serial_in     (mosi),
      .shift_en      (rx_shift),
      .parallel_load (1'b0),
      .parallel_in   ({RX_W{1'b0}}),
      .parallel_out  (rx_q),
      .serial_out    (rx_serial)
   );

   spi_shift_reg #(.WIDTH(DATA_WIDTH)) u_tx (
      .clk           (clk),
      .reset         (reset),
      .serial_in     (1'b0),
      .shift_en      (tx_shift),
      .parallel_load (tx_load),
      .parallel_in   (mem_rdata),
      .parallel_out  (tx_q),
      .serial_out    (tx_msb)
   );

   // Value the rx register takes on this posedge, so the last bit can be latched in the same cycle
   assign rx_next     = {rx_q[RX_W-2:0], mosi};
   assign unused_bits = ^{rx_serial, rx_q[RX_W-1], rx_next, tx_q};

   always_comb begin
      next_state     = state;
      cnt_next       = cnt;
      read_flag_next = read_flag;
      rx_shift       = 1'b0;
      tx_load        = 1'b0;
      tx_shift       = 1'b0;
      miso_upd       = 1'b0;
      addr_load      = 1'b0;
      wdata_load     = 1'b0;
      mem_we_c       = 1'b0;
      mem_re_c       = 1'b0;
      if (cs_n) begin
         next_state     = IDLE;
         cnt_next       = '0;
         read_flag_next = 1'b0;
      end else begin
         case (state)
            IDLE: next_state = GET_ADDR;
            GET_ADDR: begin
               if (sclk_posedge) begin
                  rx_shift = 1'b1;
                  if (cnt == ADDR_LAST) begin
                     addr_load = 1'b1;
                     cnt_next  = '0;
                     if (mosi == SPI_RW_READ) begin
                        next_state     = READ_REQ;
                        read_flag_next = 1'b1;
                     end else begin
                        next_state = WRITE_DATA;
                     end
                  end else begin
                     cnt_next = cnt + CNT_W'(1);
                  end
               end
            end
            READ_REQ: begin
               mem_re_c   = 1'b1;
               next_state = READ_WAIT;
            end
            READ_WAIT: begin
               tx_load    = 1'b1;
               next_state = READ_SHIFT;
            end
            // A negedge coinciding with a posedge is dropped
            READ_SHIFT: begin
               if (sclk_negedge && !sclk_posedge) begin
                  tx_shift = 1'b1;
                  miso_upd = 1'b1;
                  if (cnt == DATA_LAST) begin
                     cnt_next   = '0;
                     next_state = DONE;
                  end else begin
                     cnt_next = cnt + CNT_W'(1);
                  end
               end
            end
            WRITE_DATA: begin
               if (sclk_posedge) begin
                  rx_shift = 1'b1;
                  if (cnt == DATA_LAST) begin
                     wdata_load = 1'b1;
                     cnt_next   = '0;
                     next_state = WRITE_STB;
                  end else begin
                     cnt_next = cnt + CNT_W'(1);
                  end
               end
            end
            WRITE_STB: begin
               mem_we_c   = 1'b1;
               next_state = DONE;
            end
            DONE: next_state = DONE;
            default: next_state = IDLE;
         endcase
      end
   end

`ifndef SPI_MISO_BUFE_EN
   logic read_phase_next;
   assign read_phase_next = (next_state == READ_SHIFT) || ((next_state == DONE) && read_flag_next);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         read_flag <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         miso      <= 1'b0;
      end else begin
         state     <= next_state;
         cnt       <= cnt_next;
         read_flag <= read_flag_next;
         if (addr_load) begin
            mem_addr <= rx_next[ADDR_WIDTH:1];
         end
         if (wdata_load) begin
            mem_wdata <= rx_next[DATA_WIDTH-1:0];
         end
         // Without an external tri-state the line is parked low outside the read phase
         if (miso_upd) begin
            miso <= tx_msb;
         end
`ifndef SPI_MISO_BUFE_EN
         else if (!read_phase_next) begin
            miso <= 1'b0;
         end
`endif
      end
   end

   assign mem_we = mem_we_c & ~reset;
   assign mem_re = mem_re_c & ~reset;
   assign busy   = (state != IDLE);

`ifdef SPI_MISO_BUFE_EN
   assign miso_bufe = ~cs_n & ~reset & ((state == READ_SHIFT) || ((state == DONE) && read_flag));
`endif

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Self-checking bench for spi_slave_fsm: directed frames plus random write/read traffic against a memory model.
// Build with SPI_MISO_BUFE_EN defined or undefined; the MISO/miso_bufe expectations follow the macro.
`timescale 1ns/1ps
module tb_spi_slave_fsm;

   logic       clk = 1'b0;
   logic       reset, cs_n, mosi, sclk_posedge, sclk_negedge;
   logic [7:0] mem_rdata = 8'h00;
   logic [6:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_we, mem_re, miso, busy;
`ifdef SPI_MISO_BUFE_EN
   logic       miso_bufe;
`endif

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         last_pos_cyc = 0;
   int         we_count = 0, re_count = 0, we_cyc = 0;
   logic [6:0] we_addr = '0;
   logic [7:0] we_data = '0;
   int         proto_bad;
   logic [7:0] ref_mem [128];
   logic [7:0] dut_mem [128];

   spi_slave_fsm #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .cs_n         (cs_n),
      .mosi         (mosi),
      .sclk_posedge (sclk_posedge),
      .sclk_negedge (sclk_negedge),
      .mem_rdata    (mem_rdata),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_we       (mem_we),
      .mem_re       (mem_re),
      .miso         (miso),
      .busy         (busy)
`ifdef SPI_MISO_BUFE_EN
      ,
      .miso_bufe    (miso_bufe)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Slave-side memory: records DUT writes and answers reads one cycle after the strobe
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         we_count++;
         we_cyc  = cyc;
         we_addr = mem_addr;
         we_data = mem_wdata;
         dut_mem[mem_addr] = mem_wdata;
      end
      if (mem_re === 1'b1) begin
         re_count++;
         mem_rdata = dut_mem[mem_addr];
      end
   end

   task automatic idle_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One SCLK period: low half, rise pulse, 3-clk high half, fall pulse; returns MISO after the fall
   task automatic sclk_cycle(input logic b, output logic m);
      mosi = b;
      idle_clks(2);
      sclk_posedge = 1'b1;
      last_pos_cyc = cyc;
      @(negedge clk);
      sclk_posedge = 1'b0;
      idle_clks(3);
      sclk_negedge = 1'b1;
      @(negedge clk);
      sclk_negedge = 1'b0;
      m = miso;
   endtask

   // Drives a whole frame with cs_n left low; rd collects the 8 MISO bits after the R/W fall onwards
   task automatic run_frame(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                            input int extra, output logic [7:0] rd);
      logic [15:0] bits;
      logic        m, b, exp_bufe;
      bits      = {a, rw, wd};
      rd        = '0;
      proto_bad = 0;
      cs_n      = 1'b0;
      idle_clks(2);
      for (int i = 0; i < 16 + extra; i++) begin
         b = (i < 16) ? bits[15-i] : 1'($urandom_range(0, 1));
         sclk_cycle(b, m);
         if (rw && i >= 7 && i <= 14) rd[14-i] = m;
         exp_bufe = rw && (i >= 7);
`ifdef SPI_MISO_BUFE_EN
         if (miso_bufe !== exp_bufe) proto_bad++;
`else
         if (!exp_bufe && m !== 1'b0) proto_bad++;
`endif
      end
      idle_clks(2);
   endtask

   task automatic end_frame();
      cs_n = 1'b1;
      idle_clks(2);
   endtask

   task automatic test_reset();
      reset = 1'b1; cs_n = 1'b1; mosi = 1'b0; sclk_posedge = 1'b0; sclk_negedge = 1'b0;
      idle_clks(3);
      checks += 6;
      if (mem_addr !== 7'h00) begin errors++; $display("[TB] FAIL reset_addr: got %0h expected 0", mem_addr); end
      if (mem_wdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_wdata: got %0h expected 0", mem_wdata); end
      if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b expected 0", mem_we); end
      if (mem_re !== 1'b0) begin errors++; $display("[TB] FAIL reset_re: got %b expected 0", mem_re); end
      if (miso !== 1'b0) begin errors++; $display("[TB] FAIL reset_miso: got %b expected 0", miso); end
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      reset = 1'b0;
      idle_clks(2);
   endtask

   task automatic test_write(input logic [6:0] a, input logic [7:0] d, input logic timing);
      int         we0, re0;
      logic [7:0] rd;
      we0 = we_count; re0 = re_count;
      run_frame(a, 1'b0, d, 0, rd);
      ref_mem[a] = d;
      checks += 6;
      if (we_count - we0 !== 1) begin errors++; $display("[TB] FAIL write_we_pulses: got %0d expected 1", we_count - we0); end
      if (re_count - re0 !== 0) begin errors++; $display("[TB] FAIL write_re_pulses: got %0d expected 0", re_count - re0); end
      if (we_addr !== a) begin errors++; $display("[TB] FAIL write_addr: got %0h expected %0h", we_addr, a); end
      if (we_data !== d) begin errors++; $display("[TB] FAIL write_data: got %0h expected %0h", we_data, d); end
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL write_busy_done: got %b expected 1", busy); end
      if (proto_bad !== 0) begin errors++; $display("[TB] FAIL write_miso_idle: got %0d bad samples expected 0", proto_bad); end
      if (timing) begin
         checks++;
         if (we_cyc !== last_pos_cyc + 1) begin
            errors++; $display("[TB] FAIL write_we_timing: got cycle %0d expected %0d", we_cyc, last_pos_cyc + 1);
         end
      end
      end_frame();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL write_busy_idle: got %b expected 0", busy); end
   endtask

   task automatic test_read(input logic [6:0] a);
      int         we0, re0;
      logic [7:0] rd;
      we0 = we_count; re0 = re_count;
      run_frame(a, 1'b1, 8'h00, 0, rd);
      checks += 5;
      if (rd !== ref_mem[a]) begin errors++; $display("[TB] FAIL read_miso_bits: got %0h expected %0h", rd, ref_mem[a]); end
      if (re_count - re0 !== 1) begin errors++; $display("[TB] FAIL read_re_pulses: got %0d expected 1", re_count - re0); end
      if (we_count - we0 !== 0) begin errors++; $display("[TB] FAIL read_we_pulses: got %0d expected 0", we_count - we0); end
      if (mem_addr !== a) begin errors++; $display("[TB] FAIL read_addr: got %0h expected %0h", mem_addr, a); end
      if (proto_bad !== 0) begin errors++; $display("[TB] FAIL read_miso_outside_phase: got %0d bad samples expected 0", proto_bad); end
      end_frame();
      checks += 2;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL read_busy_idle: got %b expected 0", busy); end
`ifdef SPI_MISO_BUFE_EN
      if (miso_bufe !== 1'b0) begin errors++; $display("[TB] FAIL read_bufe_after_cs: got %b expected 0", miso_bufe); end
`else
      if (miso !== 1'b0) begin errors++; $display("[TB] FAIL read_miso_after_cs: got %b expected 0", miso); end
`endif
   endtask

   task automatic test_abort();
      int   we0, re0;
      logic m;
      we0 = we_count; re0 = re_count;
      cs_n = 1'b0;
      idle_clks(2);
      for (int i = 0; i < 5; i++) sclk_cycle(1'b1, m);
      end_frame();
      checks += 2;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
      if ((we_count - we0) + (re_count - re0) !== 0) begin
         errors++; $display("[TB] FAIL abort_strobes: got %0d expected 0", (we_count - we0) + (re_count - re0));
      end
      test_write(7'h01, 8'h3C, 1'b0);
   endtask

   task automatic test_reset_mid_write();
      int   we0;
      logic m;
      logic [10:0] bits;
      bits = {7'h15, 1'b0, 3'b110};
      we0  = we_count;
      cs_n = 1'b0;
      idle_clks(2);
      for (int i = 0; i < 11; i++) sclk_cycle(bits[10-i], m);
      reset = 1'b1;
      @(negedge clk);
      checks += 6;
      if (mem_addr !== 7'h00) begin errors++; $display("[TB] FAIL midrst_addr: got %0h expected 0", mem_addr); end
      if (mem_wdata !== 8'h00) begin errors++; $display("[TB] FAIL midrst_wdata: got %0h expected 0", mem_wdata); end
      if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL midrst_we: got %b expected 0", mem_we); end
      if (mem_re !== 1'b0) begin errors++; $display("[TB] FAIL midrst_re: got %b expected 0", mem_re); end
      if (miso !== 1'b0) begin errors++; $display("[TB] FAIL midrst_miso: got %b expected 0", miso); end
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
      cs_n  = 1'b1;
      reset = 1'b0;
      idle_clks(3);
      checks++;
      if (we_count - we0 !== 0) begin errors++; $display("[TB] FAIL midrst_no_we: got %0d expected 0", we_count - we0); end
   endtask

   task automatic test_overrun();
      int         we0;
      logic [7:0] rd;
      we0 = we_count;
      run_frame(7'h15, 1'b0, 8'hA5, 4, rd);
      ref_mem[7'h15] = 8'hA5;
      checks += 4;
      if (we_count - we0 !== 1) begin errors++; $display("[TB] FAIL overrun_we_pulses: got %0d expected 1", we_count - we0); end
      if (mem_wdata !== 8'hA5) begin errors++; $display("[TB] FAIL overrun_wdata: got %0h expected a5", mem_wdata); end
      if (mem_addr !== 7'h15) begin errors++; $display("[TB] FAIL overrun_addr: got %0h expected 15", mem_addr); end
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL overrun_busy: got %b expected 1", busy); end
      end_frame();
   endtask

   task automatic test_random(input int n);
      logic [6:0] a;
      logic [7:0] d;
      for (int i = 0; i < n; i++) begin
         a = 7'($urandom_range(0, 127));
         d = 8'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            test_write(a, d, 1'b1);
            test_read(a);
         end else begin
            test_read(a);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) begin
         ref_mem[i] = 8'($urandom);
         dut_mem[i] = ref_mem[i];
      end
      test_reset();
      test_write(7'h15, 8'hA5, 1'b1);
      test_read(7'h15);
      test_abort();
      test_reset_mid_write();
      test_overrun();
      test_random(8);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
